// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller for an external DEPTH x 5-bit register file.
// Optional almost_full/almost_empty outputs under `define FIFO_CTRL_ALMOST_EN.
module fifo_ctrl #(
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = 3,
   parameter int AF_LEVEL = 6
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   output logic [DEPTH-1:0]  wr_en,
   output logic [ADDR_W-1:0] rd_sel,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              ovf,
`ifdef FIFO_CTRL_ALMOST_EN
   output logic              udf,
   output logic              almost_full,
   output logic              almost_empty
`else
   output logic              udf
`endif
);

   logic [ADDR_W-1:0] wp;
   logic [ADDR_W-1:0] rp;
   logic              push_ok;
   logic              pop_ok;

   assign full   = (count == (ADDR_W+1)'(DEPTH));
   assign empty  = (count == '0);
   assign rd_sel = rp;

   // clear is asynchronous, so requests are masked combinationally too
   assign push_ok = push & (~full | pop) & ~clear;
   assign pop_ok  = pop & ~empty & ~clear;

   always_comb begin
      wr_en     = '0;
      wr_en[wp] = push_ok;
   end

`ifdef FIFO_CTRL_ALMOST_EN
   assign almost_full  = (count >= (ADDR_W+1)'(AF_LEVEL));
   assign almost_empty = (count <= (ADDR_W+1)'(1));
`endif

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         if (push_ok)
            wp <= wp + 1'b1;
         if (pop_ok)
            rp <= rp + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push & ~pop & full)
            ovf <= 1'b1;
         if (pop & empty)
            udf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus random traffic
// checked against a queue-based reference model and a bench-side storage array.
module tb_fifo_ctrl;

   localparam int DEPTH    = 8;
   localparam int ADDR_W   = 3;
   localparam int AF_LEVEL = 6;

   logic              clk = 1'b0;
   logic              clear;
   logic              push;
   logic              pop;
   logic [DEPTH-1:0]  wr_en;
   logic [ADDR_W-1:0] rd_sel;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              ovf;
   logic              udf;
`ifdef FIFO_CTRL_ALMOST_EN
   logic              almost_full;
   logic              almost_empty;
`endif

   fifo_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL)) dut (
      .clk(clk),
      .clear(clear),
      .push(push),
      .pop(pop),
      .wr_en(wr_en),
      .rd_sel(rd_sel),
      .full(full),
      .empty(empty),
      .count(count),
      .ovf(ovf),
`ifdef FIFO_CTRL_ALMOST_EN
      .udf(udf),
      .almost_full(almost_full),
      .almost_empty(almost_empty)
`else
      .udf(udf)
`endif
   );

   always #5 clk = ~clk;

   // stand-in for the storage registers the controller sequences
   logic [4:0] din;
   logic [4:0] mem [DEPTH];
   always @(posedge clk)
      for (int i = 0; i < DEPTH; i++)
         if (wr_en[i]) mem[i] <= din;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: the queue holds the data in FIFO order
   logic [4:0] q [$];
   int         n_push;
   int         n_pop;
   logic       m_ovf;
   logic       m_udf;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      n_push = 0;
      n_pop  = 0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   task automatic check_state();
      check("count", 32'(count), 32'(q.size()));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("rd_sel", 32'(rd_sel), 32'(n_pop % DEPTH));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("udf", 32'(udf), 32'(m_udf));
`ifdef FIFO_CTRL_ALMOST_EN
      check("almost_full", 32'(almost_full), 32'(q.size() >= AF_LEVEL));
      check("almost_empty", 32'(almost_empty), 32'(q.size() <= 1));
`endif
      if (q.size() != 0)
         check("head", 32'(mem[rd_sel]), 32'(q[0]));
   endtask

   task automatic step(input logic p, input logic r);
      logic       is_full;
      logic       is_empty;
      logic       pok;
      logic       rok;
      logic [31:0] exp_wr;
      @(negedge clk);
      push = p;
      pop  = r;
      din  = 5'($urandom);
      #1;
      is_full  = (q.size() == DEPTH);
      is_empty = (q.size() == 0);
      pok = p & (~is_full | r);
      rok = r & ~is_empty;
      exp_wr = pok ? (32'd1 << (n_push % DEPTH)) : 32'd0;
      check("wr_en", 32'(wr_en), exp_wr);
      check_state();
      @(posedge clk);
      if (rok) void'(q.pop_front());
      if (pok) q.push_back(din);
      n_push += int'(pok);
      n_pop  += int'(rok);
      if (p & ~r & is_full)  m_ovf = 1'b1;
      if (r & is_empty)      m_udf = 1'b1;
   endtask

   // asserts clear between edges with push held high
   task automatic do_clear();
      @(negedge clk);
      push  = 1'b1;
      pop   = 1'b1;
      #2;
      clear = 1'b1;
      #1;
      model_reset();
      check("clr_wr_en", 32'(wr_en), 32'd0);
      check_state();
      @(negedge clk);
      check("clr_hold_count", 32'(count), 32'd0);
      clear = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
   endtask

   initial begin
      clear = 1'b1;
      push  = 1'b0;
      pop   = 1'b0;
      din   = '0;
      model_reset();
      #1;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check_state();
      @(negedge clk);
      clear = 1'b0;

      // fill, then push on full
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("ovf_sticky", 32'(ovf), 32'd1);
      // full with push and pop for 10 cycles
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
      do_clear();

      // push and pop from empty
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      check("udf_set", 32'(udf), 32'd1);
      check("one_left", 32'(count), 32'd1);
      do_clear();

      // fill 8, pop 8, push 3 (pointer wrap)
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("wrap_count", 32'(count), 32'd3);

      // full with push and pop, ovf must stay clear
      do_clear();
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      check("pp_full_ovf", 32'(ovf), 32'd0);

      // clear at count 5 mid-operation
      do_clear();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      do_clear();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);

      // random traffic with shifting bias
      for (int i = 0; i < 600; i++) begin
         int bias;
         bias = (i / 50) % 3;
         if ($urandom_range(0, 79) == 0)
            do_clear();
         else
            step(1'($urandom_range(0, 3) > bias),
                 1'($urandom_range(0, 3) < bias + 1));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: number of 5-bit storage entries sequenced; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 3: pointer width, equals log2(DEPTH).
REQ-003 Parameter AF_LEVEL, default 6: almost-full threshold in entries; used only under FIFO_CTRL_ALMOST_EN.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port clear  input  1  asynchronous, active-high reset.
REQ-006 Port push  input  1  write request for the current cycle.
REQ-007 Port pop  input  1  read request for the current cycle.
REQ-008 Port wr_en  output  DEPTH  one-hot load enable, one bit per storage entry register.
REQ-009 Port rd_sel  output  ADDR_W  select of the output mux; indexes the head entry.
REQ-010 Port full  output  1  count equals DEPTH.
REQ-011 Port empty  output  1  count equals 0.
REQ-012 Port count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-013 Port ovf  output  1  sticky overflow flag.
REQ-014 Port udf  output  1  sticky underflow flag.
REQ-015 Ports almost_full, almost_empty  output  1 each  present only under FIFO_CTRL_ALMOST_EN.

Function
REQ-016 Internal state: write pointer wp, read pointer rp (ADDR_W bits each), count, ovf, udf; no other state.
REQ-017 Accepted push (push_ok) = push & (~full | pop); accepted pop (pop_ok) = pop & ~empty.
REQ-018 wr_en is combinational: wr_en[wp] = push_ok, all other bits 0; never more than one bit high.
REQ-019 rd_sel = rp (registered); head data is visible at the mux output with zero latency (first-word-fall-through).
REQ-020 On push_ok, wp increments by 1 at the next edge; wraps DEPTH-1 -> 0.
REQ-021 On pop_ok, rp increments by 1 at the next edge; wraps DEPTH-1 -> 0.
REQ-022 count: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
REQ-023 Written entry is readable the cycle after push_ok (entry register loads on the same edge).
REQ-024 Full with push & pop: both accepted, count stays DEPTH, ovf not set.
REQ-025 Full with push & ~pop: push ignored, wr_en all 0, pointers unchanged, ovf set at next edge.
REQ-026 Empty with pop: pop ignored, rp unchanged, udf set at next edge; a simultaneous push is still accepted (count -> 1).
REQ-027 ovf and udf stay 1 until clear; no other means of clearing.
REQ-028 full and empty are combinational decodes of count; never both 1.

Reset
REQ-029 clear asserted: wp=0, rp=0, count=0, ovf=0, udf=0 immediately, independent of clk.
REQ-030 During clear: empty=1, full=0, rd_sel=0, wr_en all 0; push/pop ignored.
REQ-031 clear mid-operation discards all occupancy; stored entry data is not required to change.
REQ-032 First push is accepted on the first rising edge after clear deasserts.

Configuration
REQ-033 Macro FIFO_CTRL_ALMOST_EN defined: almost_full = (count >= AF_LEVEL), almost_empty = (count <= 1), both combinational.
REQ-034 Macro undefined: almost_full/almost_empty ports and logic absent; all other behaviour identical.

Verification
REQ-035 Reset then 8 pushes, no pops -> wr_en walks 0x01..0x80, count 8, full=1, empty=0, ovf=0.
REQ-036 From full, 1 push without pop -> wr_en=0x00, count 8, ovf=1 and stays 1 until clear.
REQ-037 From empty, push&pop same cycle -> count 1, wp=1, rp=0, udf=1.
REQ-038 Fill 8, pop 8, push 3 -> wp and rp wrap to 0 then wp=3; rd_sel sequence 0..7,0; count 3.
REQ-039 From full, push&pop for 10 cycles -> count 8 every cycle, rd_sel advances mod 8, ovf=0.
REQ-040 count=5, assert clear between edges -> count 0, empty=1, rd_sel 0 before next edge; with FIFO_CTRL_ALMOST_EN, count 6 -> almost_full=1, count 1 -> almost_empty=1.
